imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning word-address width to memory.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive denied debug-request cycles before debug is forced to win.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 fetch_req  input  1  CPU fetch request; held until granted.
REQ-007 fetch_addr  input  32  CPU byte address; stable while fetch_req is high.
REQ-008 fetch_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-009 fetch_rvalid  output  1  fetch_rdata is valid this cycle.
REQ-010 fetch_rdata  output  DATA_W  fetched instruction word.
REQ-011 dbg_req  input  1  debug/display read request; held until granted.
REQ-012 dbg_addr  input  32  debug byte address; stable while dbg_req is high.
REQ-013 dbg_gnt  output  1  debug request accepted this cycle (combinational).
REQ-014 dbg_rvalid  output  1  dbg_rdata is valid this cycle.
REQ-015 dbg_rdata  output  DATA_W  debug read word.
REQ-016 mem_a  output  ADDR_W  memory word address, equal to granted address bits [ADDR_W+1:2].
REQ-017 mem_en  output  1  memory read enable, high only in a cycle with a grant.
REQ-018 mem_q  input  DATA_W  memory read data, valid one cycle after mem_en (synchronous read).

Function
REQ-019 At most one of fetch_gnt and dbg_gnt SHALL be high in any cycle; a grant is only issued to a requester whose req is high.
REQ-020 A grant SHALL drive mem_en=1 and mem_a from the winner's address in the same cycle; with no grant, mem_en=0 and mem_a holds its last value.
REQ-021 Read latency SHALL be exactly 1 cycle: the cycle after a grant, the winner's rvalid=1 and rdata=mem_q; the other rvalid=0.
REQ-022 rdata SHALL be registered per port and hold its last value while rvalid=0.
REQ-023 The owner FSM SHALL have states IDLE (no read in flight), RD_F (fetch read in flight) and RD_D (debug read in flight); next state is RD_F on fetch_gnt, RD_D on dbg_gnt, else IDLE, from any state.
REQ-024 Back-to-back grants SHALL be supported every cycle, giving full throughput with no bubble between owners.
REQ-025 Default priority: fetch wins when both requests are high.
REQ-026 The address bits above ADDR_W+1 and bits [1:0] SHALL be ignored (wrap-around modulo 2^ADDR_W words).
REQ-027 A request that drops before being granted SHALL be discarded silently, with no grant and no rvalid.

Reset
REQ-028 While rst=1: fetch_gnt=0, dbg_gnt=0, mem_en=0, and the FSM is forced to IDLE, regardless of request inputs.
REQ-029 The cycle after rst is released: fetch_rvalid=0, dbg_rvalid=0, fetch_rdata=0, dbg_rdata=0, mem_a=0, and the starvation counter is 0.
REQ-030 Reset asserted while a read is in flight SHALL suppress that read's rvalid.

Configuration
REQ-031 Macro IMEM_ARB_STARVE_GUARD_EN defined: a saturating counter (width clog2(STARVE_MAX+1)) increments on each cycle with dbg_req=1 and dbg_gnt=0, and clears on dbg_gnt or dbg_req=0.
REQ-032 When the counter equals STARVE_MAX, debug SHALL win over a simultaneous fetch_req in that cycle.
REQ-033 Macro not defined: no counter SHALL exist, strict fetch priority applies, and debug is granted only in cycles where fetch_req=0.

Verification
REQ-034 Fetch only: fetch_req=1, fetch_addr=0x0000_0010 -> same cycle fetch_gnt=1, mem_a=0x04, mem_en=1; next cycle fetch_rvalid=1 and fetch_rdata=mem_q.
REQ-035 Simultaneous requests: fetch_req=1 and dbg_req=1 in one cycle, guard off -> fetch_gnt=1 and dbg_gnt=0; dbg_gnt=1 in the first cycle fetch_req=0.
REQ-036 Starvation (guard on, STARVE_MAX=4): both requests held high -> dbg denied for 4 cycles, dbg_gnt=1 in the 5th cycle, fetch_gnt=1 again in the 6th cycle.
REQ-037 Alternating owners: fetch granted in cycle n and dbg granted in cycle n+1 -> fetch_rvalid in n+1 and dbg_rvalid in n+2, each carrying its own mem_q.
REQ-038 Wrap: dbg_addr=0x0000_0404 with ADDR_W=8 -> mem_a=0x01.
REQ-039 Reset mid-read: rst=1 in the cycle after a fetch grant -> fetch_rvalid=0 and fetch_rdata=0 after reset.

Source files
------------

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Two-port read arbiter in front of a single synchronous-read instruction
// memory. The CPU fetch port and the debug/display port compete for one
// memory read per cycle. When both request, fetch wins. Grants are
// combinational, so a new read can be issued every cycle. Read data returns
// exactly one cycle after the grant, on the port that won.
//
// Optional feature (macro IMEM_ARB_STARVE_GUARD_EN):
//   A saturating starvation counter tracks consecutive denied debug cycles.
//   When it reaches STARVE_MAX, debug beats a simultaneous fetch request.
//   If the macro is undefined, no counter exists and fetch priority is strict.
//
// Parameters:
//   ADDR_W      word-address width to memory
//   DATA_W      instruction word width
//   STARVE_MAX  denied debug cycles before debug is forced to win
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   fetch_req/addr  CPU fetch request and byte address
//   fetch_gnt       fetch accepted this cycle (combinational)
//   fetch_rvalid    fetch_rdata valid this cycle
//   fetch_rdata     fetched word, held while fetch_rvalid=0
//   dbg_req/addr    debug request and byte address
//   dbg_gnt         debug accepted this cycle (combinational)
//   dbg_rvalid      dbg_rdata valid this cycle
//   dbg_rdata       debug word, held while dbg_rvalid=0
//   mem_a, mem_en   memory word address and read enable
//   mem_q           memory read data, one cycle after mem_en
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              dbg_req,
    input  logic [31:0]       dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_F = 2'd1,
        RD_D = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] mem_a_q;
    logic [ADDR_W-1:0] gnt_word;
    logic [DATA_W-1:0] fetch_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    // Bits outside the word index are deliberately ignored. The index wraps
    // modulo 2^ADDR_W words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0],
                                dbg_addr[31:ADDR_W+2],   dbg_addr[1:0]};

`ifdef IMEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));

    // Counts consecutive cycles in which debug asked and lost. It saturates at
    // STARVE_MAX so that the forced win persists until debug is served.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            starve_cnt <= '0;
        end else if (!starve_hit) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`endif

    // Grant decision. At most one grant is issued, only to an active requester,
    // and never during reset.
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fetch_gnt = 1'b0;
        dbg_gnt   = 1'b0;
        if (!rst) begin
`ifdef IMEM_ARB_STARVE_GUARD_EN
            if (dbg_req && (!fetch_req || starve_hit)) begin
                dbg_gnt = 1'b1;
            end else if (fetch_req) begin
                fetch_gnt = 1'b1;
            end
`else
            if (fetch_req) begin
                fetch_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
`endif
        end
    end

    assign mem_en   = fetch_gnt | dbg_gnt;
    assign gnt_word = fetch_gnt ? fetch_addr[ADDR_W+1:2] : dbg_addr[ADDR_W+1:2];

    // mem_a follows the winner in the grant cycle. Otherwise it holds the last
    // address issued.
    assign mem_a = mem_en ? gnt_word : mem_a_q;

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_a_q <= '0;
        end else if (mem_en) begin
            mem_a_q <= gnt_word;
        end
    end

    // Owner FSM: it remembers which port the in-flight read belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (fetch_gnt) begin
            state_nxt = RD_F;
        end else if (dbg_gnt) begin
            state_nxt = RD_D;
        end
    end

    // A reset that lands while a read is in flight kills its rvalid.
    assign fetch_rvalid = (state == RD_F) && !rst;
    assign dbg_rvalid   = (state == RD_D) && !rst;

    // mem_q is only valid in the rvalid cycle. It is passed straight through
    // then and captured, so rdata holds that word afterwards without adding
    // a second cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_rdata_q <= '0;
            dbg_rdata_q   <= '0;
        end else begin
            if (fetch_rvalid) begin
                fetch_rdata_q <= mem_q;
            end
            if (dbg_rvalid) begin
                dbg_rdata_q <= mem_q;
            end
        end
    end

    assign fetch_rdata = fetch_rvalid ? mem_q : fetch_rdata_q;
    assign dbg_rdata   = dbg_rvalid   ? mem_q : dbg_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Self-checking bench for imem_arbiter. A cycle-level reference model is
// built from the arbitration rules: who wins, which word index results from a
// byte address, and what each port should read back one cycle later. The
// model is compared against the DUT every cycle. A behavioural synchronous
// memory supplies mem_q. Directed scenarios add explicit checks on top.
// Define IMEM_ARB_STARVE_GUARD_EN for both files to exercise the guard.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              dbg_req;
    logic [31:0]       dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_en;
    logic [DATA_W-1:0] mem_q;

    imem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_rvalid(fetch_rvalid),
        .fetch_rdata (fetch_rdata),
        .dbg_req     (dbg_req),
        .dbg_addr    (dbg_addr),
        .dbg_gnt     (dbg_gnt),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata),
        .mem_a       (mem_a),
        .mem_en      (mem_en),
        .mem_q       (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous-read memory. When no read is issued, mem_q
    // carries junk, so a port that fails to hold its rdata shows up.
    logic [DATA_W-1:0] mem_arr [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_en) mem_q <= mem_arr[mem_a];
        else        mem_q <= $urandom;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state.
    logic              m_pend_f;
    logic              m_pend_d;
    int                m_pend_idx;
    int                m_last_idx;
    logic [DATA_W-1:0] m_frd;
    logic [DATA_W-1:0] m_drd;
`ifdef IMEM_ARB_STARVE_GUARD_EN
    int                m_starve;
`endif

    // Values observed in the most recent cycle, for use by the directed checks.
    logic              obs_fg, obs_dg, obs_en, obs_frv, obs_drv;
    logic [ADDR_W-1:0] obs_a;
    logic [DATA_W-1:0] obs_frd, obs_drd;

    function automatic int word_idx(input logic [31:0] byte_addr);
        return int'(byte_addr / 4) % DEPTH;
    endfunction

    // Drives one cycle of inputs and samples outputs at the falling edge. It
    // compares every output against the model, then advances the model.
    task automatic cycle_model(input logic r, input logic fr, input logic [31:0] fa,
                               input logic dr, input logic [31:0] da);
        logic efg, edg;
        int   ea;
        rst = r; fetch_req = fr; fetch_addr = fa; dbg_req = dr; dbg_addr = da;
        @(negedge clk);
        cyc++;
        obs_fg = fetch_gnt; obs_dg = dbg_gnt; obs_en = mem_en; obs_a = mem_a;
        obs_frv = fetch_rvalid; obs_drv = dbg_rvalid;
        obs_frd = fetch_rdata; obs_drd = dbg_rdata;

        efg = 1'b0;
        edg = 1'b0;
        if (!r) begin
            efg = fr;
            edg = dr && !fr;
`ifdef IMEM_ARB_STARVE_GUARD_EN
            if (fr && dr && m_starve == STARVE_MAX) begin
                efg = 1'b0;
                edg = 1'b1;
            end
`endif
        end
        ea = efg ? word_idx(fa) : (edg ? word_idx(da) : m_last_idx);

        n_checks++;
        if (obs_fg !== efg) begin
            n_fail++; $display("FAIL fetch_gnt cyc=%0d: got %b expected %b", cyc, obs_fg, efg);
        end
        n_checks++;
        if (obs_dg !== edg) begin
            n_fail++; $display("FAIL dbg_gnt cyc=%0d: got %b expected %b", cyc, obs_dg, edg);
        end
        n_checks++;
        if (obs_en !== (efg | edg)) begin
            n_fail++; $display("FAIL mem_en cyc=%0d: got %b expected %b", cyc, obs_en, efg | edg);
        end

        if (r) begin
            n_checks++;
            if (obs_frv !== 1'b0 || obs_drv !== 1'b0) begin
                n_fail++;
                $display("FAIL rvalid_in_reset cyc=%0d: got f=%b d=%b expected 0 0", cyc, obs_frv, obs_drv);
            end
        end else begin
            n_checks++;
            if (obs_a !== ADDR_W'(ea)) begin
                n_fail++; $display("FAIL mem_a cyc=%0d: got %h expected %h", cyc, obs_a, ADDR_W'(ea));
            end
            n_checks++;
            if (obs_frv !== m_pend_f) begin
                n_fail++; $display("FAIL fetch_rvalid cyc=%0d: got %b expected %b", cyc, obs_frv, m_pend_f);
            end
            n_checks++;
            if (obs_frd !== (m_pend_f ? mem_arr[m_pend_idx] : m_frd)) begin
                n_fail++;
                $display("FAIL fetch_rdata cyc=%0d: got %h expected %h", cyc, obs_frd,
                         m_pend_f ? mem_arr[m_pend_idx] : m_frd);
            end
            n_checks++;
            if (obs_drv !== m_pend_d) begin
                n_fail++; $display("FAIL dbg_rvalid cyc=%0d: got %b expected %b", cyc, obs_drv, m_pend_d);
            end
            n_checks++;
            if (obs_drd !== (m_pend_d ? mem_arr[m_pend_idx] : m_drd)) begin
                n_fail++;
                $display("FAIL dbg_rdata cyc=%0d: got %h expected %h", cyc, obs_drd,
                         m_pend_d ? mem_arr[m_pend_idx] : m_drd);
            end
        end

        if (r) begin
            m_pend_f = 1'b0; m_pend_d = 1'b0; m_pend_idx = 0; m_last_idx = 0;
            m_frd = '0; m_drd = '0;
`ifdef IMEM_ARB_STARVE_GUARD_EN
            m_starve = 0;
`endif
        end else begin
            if (m_pend_f) m_frd = mem_arr[m_pend_idx];
            if (m_pend_d) m_drd = mem_arr[m_pend_idx];
            m_pend_f = efg;
            m_pend_d = edg;
            if (efg || edg) begin
                m_pend_idx = ea;
                m_last_idx = ea;
            end
`ifdef IMEM_ARB_STARVE_GUARD_EN
            if (!dr || edg) m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve++;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle_model(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        // Requests held high during reset must not be granted.
        cycle_model(1'b1, 1'b1, 32'h10, 1'b1, 32'h20);
        cycle_model(1'b1, 1'b1, 32'h10, 1'b1, 32'h20);
        n_checks++;
        if (obs_fg !== 1'b0 || obs_dg !== 1'b0 || obs_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_grants: got fg=%b dg=%b en=%b expected 0 0 0", obs_fg, obs_dg, obs_en);
        end
        idle();
        n_checks++;
        if (obs_frv !== 1'b0 || obs_drv !== 1'b0 || obs_frd !== '0 || obs_drd !== '0 || obs_a !== '0) begin
            n_fail++;
            $display("FAIL post_reset_state: got frv=%b drv=%b frd=%h drd=%h a=%h expected all zero",
                     obs_frv, obs_drv, obs_frd, obs_drd, obs_a);
        end
    endtask

    task automatic test_fetch_only();
        cycle_model(1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0);
        n_checks++;
        if (obs_fg !== 1'b1 || obs_a !== 8'h04 || obs_en !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_only_grant: got fg=%b a=%h en=%b expected 1 04 1", obs_fg, obs_a, obs_en);
        end
        idle();
        n_checks++;
        if (obs_frv !== 1'b1 || obs_frd !== mem_arr[4]) begin
            n_fail++;
            $display("FAIL fetch_only_data: got v=%b d=%h expected 1 %h", obs_frv, obs_frd, mem_arr[4]);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) begin
            cycle_model(1'b0, 1'b1, 32'h100 + 32'(i * 4), 1'b1, 32'h200);
            n_checks++;
            if (obs_fg !== 1'b1 || obs_dg !== 1'b0) begin
                n_fail++;
                $display("FAIL simul_fetch_wins: got fg=%b dg=%b expected 1 0", obs_fg, obs_dg);
            end
        end
        cycle_model(1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
        n_checks++;
        if (obs_dg !== 1'b1) begin
            n_fail++; $display("FAIL simul_dbg_after_fetch_drop: got %b expected 1", obs_dg);
        end
        idle();
    endtask

    task automatic test_starvation();
        logic [5:0] dg_seen;
        logic [5:0] fg_seen;
        for (int i = 0; i < 6; i++) begin
            cycle_model(1'b0, 1'b1, 32'h300 + 32'(i * 4), 1'b1, 32'h3F0);
            dg_seen[i] = obs_dg;
            fg_seen[i] = obs_fg;
        end
        cycle_model(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();
`ifdef IMEM_ARB_STARVE_GUARD_EN
        n_checks++;
        if (dg_seen !== 6'b01_0000 || fg_seen !== 6'b10_1111) begin
            n_fail++;
            $display("FAIL starve_pattern: got dg=%b fg=%b expected 010000 101111", dg_seen, fg_seen);
        end
`else
        n_checks++;
        if (dg_seen !== 6'b00_0000 || fg_seen !== 6'b11_1111) begin
            n_fail++;
            $display("FAIL strict_priority: got dg=%b fg=%b expected 000000 111111", dg_seen, fg_seen);
        end
`endif
    endtask

    task automatic test_alternating();
        cycle_model(1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        cycle_model(1'b0, 1'b0, 32'h0, 1'b1, 32'h44);
        n_checks++;
        if (obs_dg !== 1'b1 || obs_frv !== 1'b1 || obs_frd !== mem_arr[8]) begin
            n_fail++;
            $display("FAIL alt_fetch_return: got dg=%b frv=%b frd=%h expected 1 1 %h",
                     obs_dg, obs_frv, obs_frd, mem_arr[8]);
        end
        idle();
        n_checks++;
        if (obs_drv !== 1'b1 || obs_frv !== 1'b0 || obs_drd !== mem_arr[17]) begin
            n_fail++;
            $display("FAIL alt_dbg_return: got drv=%b frv=%b drd=%h expected 1 0 %h",
                     obs_drv, obs_frv, obs_drd, mem_arr[17]);
        end
        idle();
    endtask

    task automatic test_wrap();
        cycle_model(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0404);
        n_checks++;
        if (obs_a !== 8'h01) begin
            n_fail++; $display("FAIL wrap_dbg: got %h expected 01", obs_a);
        end
        cycle_model(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        n_checks++;
        if (obs_a !== 8'hFF) begin
            n_fail++; $display("FAIL wrap_fetch: got %h expected ff", obs_a);
        end
        idle();
        idle();
    endtask

    task automatic test_drop();
        cycle_model(1'b0, 1'b1, 32'h50, 1'b1, 32'h60);
        cycle_model(1'b0, 1'b1, 32'h54, 1'b0, 32'h0);
        idle();
        idle();
        n_checks++;
        if (obs_drv !== 1'b0 || obs_dg !== 1'b0) begin
            n_fail++; $display("FAIL drop_discarded: got drv=%b dg=%b expected 0 0", obs_drv, obs_dg);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) cycle_model(1'b0, 1'b1, 32'(i * 8), 1'b0, 32'h0);
            else            cycle_model(1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 12));
            n_checks++;
            if (obs_en !== 1'b1) begin
                n_fail++; $display("FAIL back_to_back_bubble: cyc=%0d got %b expected 1", cyc, obs_en);
            end
        end
        idle();
        idle();
    endtask

    task automatic test_reset_mid_read();
        cycle_model(1'b0, 1'b1, 32'h30, 1'b0, 32'h0);
        cycle_model(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++;
        if (obs_frv !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_read_rvalid: got %b expected 0", obs_frv);
        end
        idle();
        n_checks++;
        if (obs_frv !== 1'b0 || obs_frd !== '0) begin
            n_fail++; $display("FAIL reset_mid_read_after: got v=%b d=%h expected 0 0", obs_frv, obs_frd);
        end
    endtask

    task automatic test_random();
        logic r, fr, dr;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            fr = ($urandom_range(0, 2) != 0);
            dr = ($urandom_range(0, 1) != 0);
            cycle_model(r, fr, $urandom, dr, $urandom);
        end
        idle();
        idle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_arr[i] = $urandom;
        mem_q = '0;
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; dbg_req = 1'b0; dbg_addr = '0;
        m_pend_f = 1'b0; m_pend_d = 1'b0; m_pend_idx = 0; m_last_idx = 0;
        m_frd = '0; m_drd = '0;
`ifdef IMEM_ARB_STARVE_GUARD_EN
        m_starve = 0;
`endif
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_alternating();
        test_wrap();
        test_drop();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
